snake_dir_queue: RTL and testbench
==================================

# snake_dir_queue

Buffers player direction commands between the PS/2 keyboard tracker and the snake control FSM, so that quick successive presses inside one move period are all honoured in order. It edge-detects the four arrow inputs and drops illegal requests: repeats of the previous direction and 180° reversals. Accepted requests go into a small FIFO. One entry is released into the committed `direction` register per game step (`tick`). The block replaces direct level-sampling of the keys by the control FSM.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..8.
- `clk` input 1: system clock (CLOCK_50 domain).
- `reset` input 1: synchronous, active-high.
- `restart` input 1: synchronous game-over clear; same effect as `reset`.
- `left`, `right`, `up`, `down` input 1 each: key levels from keyboard_tracker; pulse or hold mode both supported.
- `tick` input 1: one-cycle strobe from control, asserted when the snake commits a move.
- `direction` output 2: committed heading; LEFT=0, RIGHT=1, UP=2, DOWN=3.
- `dir_changed` output 1: one-cycle pulse in the cycle after `direction` is updated by a pop.
- `pending` output clog2(DEPTH+1): number of queued entries.
- `overflow` output 1: one-cycle pulse when an accepted request is lost because the FIFO is full.

## Operation
- Edge detect: a key registers a request only on the cycle its level goes 0→1, using a one-cycle registered copy per key. Holding a key produces exactly one request.
- Several rising edges in the same cycle: only one request is taken. Priority is down > up > right > left; the others are discarded.
- Reference direction for filtering: the FIFO tail entry if `pending`>0, otherwise `direction`.
- A request is rejected, with no side effects and no `overflow`, if it equals the reference direction or is its opposite (0↔1, 2↔3).
- A legal request with `pending`==DEPTH sets `overflow` for one cycle. The request is dropped and FIFO contents are unchanged.
- A legal request otherwise is written at the tail, and `pending` increments.
- Pop: on `tick` with `pending`>0, the head entry is loaded into `direction`, `pending` decrements, and `dir_changed` pulses next cycle.
- `tick` with an empty FIFO: `direction` holds and there is no pulse.
- Push and pop in the same cycle: both occur and `pending` is unchanged. The push filter uses the pre-pop reference. The pushed entry is never popped in the cycle it is written (no bypass).
- Full FIFO, legal request, and `tick` in the same cycle: the pop frees a slot, so the push is accepted and there is no `overflow`.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `pending` is tracked separately, so full and empty are unambiguous.

## Timing
- Values on `reset` or `restart`:
  - `direction`=RIGHT (1)
  - `pending`=0
  - `dir_changed`=0
  - `overflow`=0
  - both pointers 0
  - edge registers loaded with the current key levels, so a key held through reset makes no request
- Reset behaviour: reset and restart mid-operation discard all queued entries. `restart` has priority over `tick` and key edges in the same cycle.
- Latency from key rising edge (cycle N) to the FIFO write: the write is visible in `pending` at N+1.
- Latency from `tick` (cycle T) to the new value: `direction` is valid from T+1, and `dir_changed` is high during T+1.
- Throughput: at most one push and one pop per cycle.
- Outputs: all are registered; there are no combinational paths from inputs to outputs.

## Structure
- `snake_pkg` holds:
  - the LEFT/RIGHT/UP/DOWN localparams
  - the reset heading RIGHT
  - an `opposite(dir)` function, shared with control and datapath
- Sub-module `key_rise_detect`: one register and an AND per key, instantiated four times, with a reset input that loads the current level.
- FIFO storage is a DEPTH×2 register array. No RAM inference.

## Test plan
- Press up at cycle 10 and tick at cycle 20 → `pending`=1 at cycle 11, `direction`=2 and `dir_changed`=1 at cycle 21, `pending`=0.
- With `direction`=RIGHT and the queue empty, press left, then right → both rejected, `pending` stays 0, no `overflow`.
- Press up, left, down, right with no tick (legal chain; the tail changes each time) → `pending`=4. A fifth legal press (up) → `overflow` pulses and `pending` stays 4. Then four ticks yield `direction`=2, 0, 3, 1 in order.
- With the queue full (DEPTH=4), a legal press and `tick` in the same cycle → no `overflow`, `pending` stays 4, the head is popped.
- Up and down rising in the same cycle with `direction`=RIGHT → only down is queued, `pending`=1.
- Two queued entries, then `restart` asserted together with `tick` → `direction`=1 and `pending`=0 next cycle, no `dir_changed`. Hold up through the restart → no request after it is released.

Source files
------------

// File: rtl/snake_dir_queue_pkg.sv
// rtl/snake_dir_queue_pkg.sv - shared heading encoding and helpers for the snake game
// Exports: dir_t, LEFT/RIGHT/UP/DOWN codes, DIR_RESET heading, opposite().
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t LEFT  = 2'd0;
    localparam dir_t RIGHT = 2'd1;
    localparam dir_t UP    = 2'd2;
    localparam dir_t DOWN  = 2'd3;

    // Heading the snake starts with after reset or game-over restart.
    localparam dir_t DIR_RESET = RIGHT;

    // Opposite pairs differ only in bit 0 (LEFT/RIGHT, UP/DOWN).
    function automatic dir_t opposite(input dir_t dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage

// File: rtl/snake_dir_queue_if.sv
// rtl/snake_dir_queue_if.sv - key/tick inputs and heading outputs of the direction queue
// master: drives left/right/up/down/tick, observes direction/dir_changed/pending/overflow.
// slave : the queue itself.
interface snake_dir_queue_if #(
    parameter int DEPTH = 4
);
    import snake_pkg::*;

    localparam int PW = $clog2(DEPTH + 1);

    logic          left;
    logic          right;
    logic          up;
    logic          down;
    logic          tick;
    dir_t          direction;
    logic          dir_changed;
    logic [PW-1:0] pending;
    logic          overflow;

    modport master (
        output left, right, up, down, tick,
        input  direction, dir_changed, pending, overflow
    );

    modport slave (
        input  left, right, up, down, tick,
        output direction, dir_changed, pending, overflow
    );

endinterface

// File: rtl/snake_dir_queue_key_rise_detect.sv
// rtl/snake_dir_queue_key_rise_detect.sv - 0->1 edge detector for one key level
// Ports: clk, load (reset/restart: capture level, suppress edge), level in, rise out.
module key_rise_detect (
    input  logic clk,
    input  logic load,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // The register always tracks the level; during load it still captures the
    // current level so a key held through reset is not seen as a new press.
    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            prev_q <= level;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q & ~load;

endmodule

// File: rtl/snake_dir_queue.sv
// rtl/snake_dir_queue.sv - filtered FIFO of player headings released one per game tick
// Ports: clk, reset (sync, active-high), restart (same effect as reset),
//        bus (slave): key levels + tick in; direction, dir_changed, pending, overflow out.
module snake_dir_queue
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    snake_dir_queue_if.slave   bus
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic clear;
    assign clear = reset | restart;

    // ---------------------------------------------------------------
    // Edge detection, indexed by heading code
    // ---------------------------------------------------------------
    logic [3:0] rise;

    key_rise_detect u_rise_left  (.clk(clk), .load(clear), .level(bus.left),  .rise(rise[LEFT]));
    key_rise_detect u_rise_right (.clk(clk), .load(clear), .level(bus.right), .rise(rise[RIGHT]));
    key_rise_detect u_rise_up    (.clk(clk), .load(clear), .level(bus.up),    .rise(rise[UP]));
    key_rise_detect u_rise_down  (.clk(clk), .load(clear), .level(bus.down),  .rise(rise[DOWN]));

    logic req_valid;
    dir_t req_dir;

    // Simultaneous presses: highest code wins (down > up > right > left).
    always_comb begin
        req_valid = |rise;
        req_dir   = LEFT;
        if (rise[DOWN]) begin
            req_dir = DOWN;
        end else if (rise[UP]) begin
            req_dir = UP;
        end else if (rise[RIGHT]) begin
            req_dir = RIGHT;
        end
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    dir_t          dir_q,         dir_d;
    logic          dir_changed_q, dir_changed_d;
    logic          overflow_q,    overflow_d;
    logic [PW-1:0] pending_q,     pending_d;
    logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
    dir_t          fifo_q [DEPTH];
    dir_t          fifo_d [DEPTH];

    logic [AW-1:0] tail_ptr;
    dir_t          ref_dir;
    logic          legal;
    logic          full;
    logic          pop;
    logic          push;

    always_comb begin
        dir_d         = dir_q;
        dir_changed_d = 1'b0;
        overflow_d    = 1'b0;
        pending_d     = pending_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_d        = fifo_q;

        // Requests are judged against where the snake will be heading once
        // everything already queued has been played out.
        tail_ptr = wr_ptr_q - AW'(1);
        ref_dir  = (pending_q != '0) ? fifo_q[tail_ptr] : dir_q;

        legal = req_valid && (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
        full  = (pending_q == PW'(DEPTH));
        pop   = bus.tick && (pending_q != '0);
        // A pop in the same cycle frees the slot a full queue needs.
        push  = legal && (!full || pop);

        overflow_d    = legal && full && !pop;
        dir_changed_d = pop;

        if (pop) begin
            dir_d    = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push) begin
            fifo_d[wr_ptr_q] = req_dir;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            dir_q         <= DIR_RESET;
            dir_changed_q <= 1'b0;
            overflow_q    <= 1'b0;
            pending_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= DIR_RESET;
            end
        end else begin
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            overflow_q    <= overflow_d;
            pending_q     <= pending_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_q        <= fifo_d;
        end
    end

    assign bus.direction   = dir_q;
    assign bus.dir_changed = dir_changed_q;
    assign bus.overflow    = overflow_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_snake_dir_queue.sv
// tb/tb_snake_dir_queue.sv - self-checking bench for snake_dir_queue
module tb_snake_dir_queue;
    import snake_pkg::*;

    localparam int DEPTH = 4;

    localparam bit [3:0] K0  = 4'b0000;
    localparam bit [3:0] K_L = 4'b0001;
    localparam bit [3:0] K_R = 4'b0010;
    localparam bit [3:0] K_U = 4'b0100;
    localparam bit [3:0] K_D = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    logic restart;

    always #5 clk = ~clk;

    snake_dir_queue_if #(.DEPTH(DEPTH)) bus ();

    snake_dir_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: committed heading plus a queue of pending headings.
    int       m_dir;
    int       m_q[$];
    bit [3:0] m_prev;
    bit       m_chg;
    bit       m_ovf;
    bit       m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit [3:0] k, input bit tk, input bit clr);
        bit [3:0] rises;
        int  req;
        int  refd;
        bit  legal;
        bit  full;
        bit  popping;
        if (clr) begin
            m_dir   = 1;
            m_q.delete();
            m_chg   = 1'b0;
            m_ovf   = 1'b0;
            m_prev  = k;
            m_valid = 1'b1;
            return;
        end
        rises = k & ~m_prev;
        req   = -1;
        for (int i = 0; i < 4; i++) begin
            if (rises[i]) req = i;
        end
        refd    = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
        legal   = (req >= 0) && (req != refd) && ((req ^ 1) != refd);
        full    = (m_q.size() == DEPTH);
        popping = tk && (m_q.size() > 0);
        m_chg   = popping;
        m_ovf   = legal && full && !popping;
        if (popping) m_dir = m_q.pop_front();
        if (legal && !(full && !popping)) m_q.push_back(req);
        m_prev = k;
    endtask

    task automatic compare_model();
        if (m_valid) begin
            chk("direction",   int'(bus.direction),   m_dir);
            chk("pending",     int'(bus.pending),     m_q.size());
            chk("dir_changed", int'(bus.dir_changed), int'(m_chg));
            chk("overflow",    int'(bus.overflow),    int'(m_ovf));
        end
    endtask

    // One clock: drive at negedge-side, model at posedge, compare at negedge.
    task automatic cyc(input bit [3:0] k, input bit tk = 1'b0,
                       input bit rs = 1'b0, input bit rt = 1'b0);
        {bus.down, bus.up, bus.right, bus.left} = k;
        bus.tick = tk;
        reset    = rs;
        restart  = rt;
        @(posedge clk);
        model_step(k, tk, rs | rt);
        @(negedge clk);
        compare_model();
    endtask

    int tick_seq[4] = '{2, 0, 3, 1};

    initial begin
        {bus.down, bus.up, bus.right, bus.left} = 4'b0000;
        bus.tick = 1'b0;
        reset    = 1'b1;
        restart  = 1'b0;

        // Reset state
        repeat (3) cyc(K0, 1'b0, 1'b1);
        chk("rst_direction",   int'(bus.direction),   1);
        chk("rst_pending",     int'(bus.pending),     0);
        chk("rst_dir_changed", int'(bus.dir_changed), 0);
        chk("rst_overflow",    int'(bus.overflow),    0);
        repeat (6) cyc(K0);

        // Single press then tick
        cyc(K_U);
        chk("up_push_pending", int'(bus.pending), 1);
        repeat (8) cyc(K0);
        cyc(K0, 1'b1);
        chk("up_tick_direction", int'(bus.direction),   2);
        chk("up_tick_changed",   int'(bus.dir_changed), 1);
        chk("up_tick_pending",   int'(bus.pending),     0);
        cyc(K0);
        chk("changed_one_cycle", int'(bus.dir_changed), 0);

        // Repeat and reversal rejected
        cyc(K0, 1'b0, 1'b0, 1'b1);
        cyc(K_L);
        chk("reverse_pending",  int'(bus.pending),  0);
        chk("reverse_overflow", int'(bus.overflow), 0);
        cyc(K0);
        cyc(K_R);
        chk("repeat_pending",  int'(bus.pending),  0);
        chk("repeat_overflow", int'(bus.overflow), 0);
        cyc(K0);

        // Fill, overflow, drain in order
        cyc(K_U); cyc(K0); cyc(K_L); cyc(K0);
        cyc(K_D); cyc(K0); cyc(K_R); cyc(K0);
        chk("fill_pending", int'(bus.pending), 4);
        cyc(K_U);
        chk("ovf_pulse",   int'(bus.overflow), 1);
        chk("ovf_pending", int'(bus.pending),  4);
        cyc(K0);
        chk("ovf_one_cycle", int'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(K0, 1'b1);
            chk("drain_direction", int'(bus.direction), tick_seq[i]);
            cyc(K0);
        end
        chk("drain_pending", int'(bus.pending), 0);

        // Full queue, legal press together with tick
        cyc(K_U); cyc(K0); cyc(K_L); cyc(K0);
        cyc(K_D); cyc(K0); cyc(K_R); cyc(K0);
        cyc(K_U, 1'b1);
        chk("full_tick_overflow",  int'(bus.overflow),  0);
        chk("full_tick_pending",   int'(bus.pending),   4);
        chk("full_tick_direction", int'(bus.direction), 2);
        cyc(K0);

        // Simultaneous up+down from RIGHT
        cyc(K0, 1'b0, 1'b0, 1'b1);
        cyc(K_U | K_D);
        chk("simul_pending", int'(bus.pending), 1);
        cyc(K0);
        cyc(K0, 1'b1);
        chk("simul_direction", int'(bus.direction), 3);
        cyc(K0);

        // Restart with tick and a held key
        cyc(K0, 1'b0, 1'b0, 1'b1);
        cyc(K_U); cyc(K0); cyc(K_L); cyc(K0);
        chk("two_queued", int'(bus.pending), 2);
        cyc(K_U, 1'b1, 1'b0, 1'b1);
        chk("restart_direction", int'(bus.direction),   1);
        chk("restart_pending",   int'(bus.pending),     0);
        chk("restart_changed",   int'(bus.dir_changed), 0);
        repeat (3) cyc(K_U);
        cyc(K0);
        chk("held_through_restart", int'(bus.pending), 0);

        // Hold mode: one request per press
        repeat (4) cyc(K_D);
        chk("hold_one_request", int'(bus.pending), 1);
        cyc(K0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
